// File: rtl/wb_arbiter3.sv
// wb_arbiter3: round-robin arbiter that merges three execute-unit results
// (A = ALU, B = MUL/DIV, C = LSU) onto one registered writeback bus.
// Optional grant/stall statistics counters are built in when the macro
// WB_ARB_STATS_EN is defined.
module wb_arbiter3 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic             c_valid,
    input  logic [WIDTH-1:0] c_data,
    output logic             c_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b,
    output logic [15:0]      cnt_c,
    output logic [15:0]      cnt_stall
`endif
);

    localparam int unsigned SEL_W = 2;
    localparam logic [SEL_W-1:0] SEL_A = 2'd0;
    localparam logic [SEL_W-1:0] SEL_B = 2'd1;
    localparam logic [SEL_W-1:0] SEL_C = 2'd2;

    logic [SEL_W-1:0] last;
    logic             free_c;
    logic [2:0]       grant_c;
    logic [SEL_W-1:0] grant_sel_c;
    logic [WIDTH-1:0] grant_data_c;

    assign free_c = !out_valid || out_ready;

    // Round-robin pick: search starts at the source after the last grant.
    always_comb begin
        grant_c = 3'b000;
        if (!reset && free_c) begin
            unique case (last)
                SEL_A: begin
                    if (b_valid)      grant_c = 3'b010;
                    else if (c_valid) grant_c = 3'b100;
                    else if (a_valid) grant_c = 3'b001;
                end
                SEL_B: begin
                    if (c_valid)      grant_c = 3'b100;
                    else if (a_valid) grant_c = 3'b001;
                    else if (b_valid) grant_c = 3'b010;
                end
                default: begin
                    if (a_valid)      grant_c = 3'b001;
                    else if (b_valid) grant_c = 3'b010;
                    else if (c_valid) grant_c = 3'b100;
                end
            endcase
        end
    end

    // Select code and data of the granted source for the result mux.
    always_comb begin
        grant_sel_c  = SEL_A;
        grant_data_c = a_data;
        if (grant_c[1]) begin
            grant_sel_c  = SEL_B;
            grant_data_c = b_data;
        end else if (grant_c[2]) begin
            grant_sel_c  = SEL_C;
            grant_data_c = c_data;
        end
    end

    assign a_ready = grant_c[0];
    assign b_ready = grant_c[1];
    assign c_ready = grant_c[2];

    // Output stage and last-grant pointer; a free register with no grant drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= SEL_A;
            last      <= SEL_C;
        end else if (free_c) begin
            if (grant_c != 3'b000) begin
                out_valid <= 1'b1;
                out_data  <= grant_data_c;
                out_sel   <= grant_sel_c;
                last      <= grant_sel_c;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Saturating per-source grant counters and backpressure stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a     <= '0;
            cnt_b     <= '0;
            cnt_c     <= '0;
            cnt_stall <= '0;
        end else begin
            if (grant_c[0] && cnt_a != CNT_MAX) cnt_a <= cnt_a + 16'd1;
            if (grant_c[1] && cnt_b != CNT_MAX) cnt_b <= cnt_b + 16'd1;
            if (grant_c[2] && cnt_c != CNT_MAX) cnt_c <= cnt_c + 16'd1;
            if (out_valid && !out_ready && cnt_stall != CNT_MAX)
                cnt_stall <= cnt_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter3.sv
// Bench for wb_arbiter3: directed scenarios with literal expectations plus
// randomized producers, all checked every cycle against a queue-free
// behavioural model of the round-robin writeback stage.
module tb_wb_arbiter3;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             a_valid, b_valid, c_valid;
    logic [WIDTH-1:0] a_data, b_data, c_data;
    logic             a_ready, b_ready, c_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;
`ifdef WB_ARB_STATS_EN
    logic [15:0]      cnt_a, cnt_b, cnt_c, cnt_stall;
`endif

    int errors = 0;
    int checks = 0;

    wb_arbiter3 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
`ifdef WB_ARB_STATS_EN
        , .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_stall(cnt_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model state: what the output register holds and who was served last.
    logic        m_ok = 1'b0;
    logic        m_valid;
    logic [31:0] m_data;
    int          m_sel;
    int          m_last;
    logic        acc_a = 1'b0, acc_b = 1'b0, acc_c = 1'b0;

    // Compare DUT to the model mid-cycle, then advance the model to the next edge.
    always @(negedge clk) begin
        logic        v[3];
        logic [31:0] d[3];
        logic        free;
        int          g;
        logic [2:0]  exp_rdy;
        v[0] = a_valid; v[1] = b_valid; v[2] = c_valid;
        d[0] = a_data;  d[1] = b_data;  d[2] = c_data;
        if (reset) begin
            check("ready_in_reset", {29'd0, c_ready, b_ready, a_ready}, 32'd0);
            m_valid = 1'b0; m_data = 32'd0; m_sel = 0; m_last = 2; m_ok = 1'b1;
        end else if (m_ok) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("out_sel",   {30'd0, out_sel}, 32'(m_sel));
            check("out_data",  out_data, m_data);
            free = !m_valid || out_ready;
            g = -1;
            if (free)
                for (int k = 1; k <= 3; k++)
                    if (g < 0 && v[(m_last + k) % 3]) g = (m_last + k) % 3;
            exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
            check("readies", {29'd0, c_ready, b_ready, a_ready}, {29'd0, exp_rdy});
            if (g >= 0) begin
                m_valid = 1'b1; m_data = d[g]; m_sel = g; m_last = g;
            end else if (free) begin
                m_valid = 1'b0;
            end
        end
        acc_a = a_ready; acc_b = b_ready; acc_c = c_ready;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  exp_sel[4];
        logic [31:0] exp_dat[4];
        logic [2:0]  exp_rot[4];
        exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2; exp_sel[3] = 2'd0;
        exp_dat[0] = 32'h11; exp_dat[1] = 32'h22; exp_dat[2] = 32'h33; exp_dat[3] = 32'h11;
        exp_rot[0] = 3'b001; exp_rot[1] = 3'b100; exp_rot[2] = 3'b001; exp_rot[3] = 3'b100;

        reset = 1'b1; out_ready = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_data = '0; b_data = '0; c_data = '0;
        repeat (2) cyc();

        // Rotation with all three producers valid.
        reset = 1'b0; out_ready = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
        a_data = 32'h11; b_data = 32'h22; c_data = 32'h33;
        @(negedge clk);
        check("rot_first_a_ready", {31'd0, a_ready}, 32'd1);
        check("rot_first_out_valid", {31'd0, out_valid}, 32'd0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rot_sel", {30'd0, out_sel}, {30'd0, exp_sel[i]});
            check("rot_data", out_data, exp_dat[i]);
            cyc();
        end

        // Single requester B.
        a_valid = 1'b0; c_valid = 1'b0; b_data = 32'hBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("solo_b_ready", {31'd0, b_ready}, 32'd1);
            if (i >= 1) begin
                check("solo_b_sel", {30'd0, out_sel}, 32'd1);
                check("solo_b_data", out_data, 32'hBEEF);
            end
            cyc();
        end

        // Backpressure for three cycles, then release.
        a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
        a_data = 32'h11; b_data = 32'h22; c_data = 32'h33; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_readies", {29'd0, c_ready, b_ready, a_ready}, 32'd0);
            check("bp_sel_hold", {30'd0, out_sel}, 32'd1);
            check("bp_data_hold", out_data, 32'hBEEF);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_c", {29'd0, c_ready, b_ready, a_ready}, 32'b100);
        cyc();
        @(negedge clk);
        check("bp_release_sel", {30'd0, out_sel}, 32'd2);
        check("bp_release_data", out_data, 32'h33);
        cyc();

        // Reset with out_valid=1 and last=A; B then wins over C.
        reset = 1'b1; a_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_readies", {29'd0, c_ready, b_ready, a_ready}, 32'd0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_sel", {30'd0, out_sel}, 32'd0);
        check("rst_mid_b_first", {29'd0, c_ready, b_ready, a_ready}, 32'b010);
        cyc();
        @(negedge clk);
        check("rst_mid_out_b", out_data, 32'h22);
        cyc();

        // A and C only, starting right after a C grant.
        a_valid = 1'b1; b_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ac_alt", {29'd0, c_ready, b_ready, a_ready}, {29'd0, exp_rot[i]});
            check("ac_sel_not_3", {31'd0, out_sel != 2'd3}, 32'd1);
            cyc();
        end

        // Randomized producers that hold valid/data until their ready is seen.
        for (int n = 0; n < 4000; n++) begin
            if (!a_valid || acc_a) begin a_valid = ($urandom_range(0, 99) < 60); a_data = $urandom; end
            if (!b_valid || acc_b) begin b_valid = ($urandom_range(0, 99) < 60); b_data = $urandom; end
            if (!c_valid || acc_c) begin c_valid = ($urandom_range(0, 99) < 60); c_data = $urandom; end
            out_ready = ($urandom_range(0, 99) < 70);
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end

`ifdef WB_ARB_STATS_EN
        // Counter saturation and stall counting.
        reset = 1'b1; cyc();
        reset = 1'b0; out_ready = 1'b1;
        a_valid = 1'b1; b_valid = 1'b0; c_valid = 1'b0; a_data = 32'h5A;
        repeat (70000) cyc();
        @(negedge clk);
        check("cnt_a_sat", {16'd0, cnt_a}, 32'hFFFF);
        check("cnt_b_zero", {16'd0, cnt_b}, 32'd0);
        check("cnt_c_zero", {16'd0, cnt_c}, 32'd0);
        cyc();
        out_ready = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        check("cnt_stall_5", {16'd0, cnt_stall}, 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
